// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: bridges the core's multiplexed external bus (ALE/nME/nOE/RnW,
// shared 16-bit address/data) to a request/acknowledge memory port, stalling
// the core through nWait until the access completes or times out.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for ALE; address latched when it is seen
// ADDR   | one cycle: decode read/write/no-access, capture write data
// ACCESS | request outstanding, core stalled; wait/timeout counters run
// DONE   | core released, BusOut held; leave on nME=1 or a new ALE
module ext_mem_bridge #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] BusIn,
    input  logic        ALE,
    input  logic        nME,
    input  logic        nOE,
    input  logic        RnW,
    output logic [15:0] BusOut,
    output logic        nWait,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    output logic        MemReq,
    output logic        MemWe,
    input  logic [15:0] MemRData,
    input  logic        MemAck,
    output logic        Err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  to_cnt_q,   to_cnt_d;
    logic        ack_seen_q, ack_seen_d;
    logic        nwait_q,    nwait_d;
    logic        mem_req_q,  mem_req_d;
    logic        mem_we_q,   mem_we_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic [15:0] bus_out_q,  bus_out_d;
    logic        err_q,      err_d;
    logic        ack_ok;
    logic        done_now;

    // State, counters and output registers; async reset returns every
    // output to its idle value, dropping any outstanding request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            ack_seen_q <= 1'b0;
            nwait_q    <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bus_out_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ack_seen_q <= ack_seen_d;
            nwait_q    <= nwait_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bus_out_q  <= bus_out_d;
            err_q      <= err_d;
        end
    end

    // Next-state and register updates for the access sequence.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        ack_seen_d = ack_seen_q;
        nwait_d    = nwait_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bus_out_d  = bus_out_q;
        err_d      = err_q;
        // Only the first ack of a live request counts; stray or repeated
        // acks are dropped here.
        ack_ok     = MemAck && mem_req_q && !ack_seen_q;
        done_now   = (ack_seen_q || ack_ok) && (wait_cnt_q == 4'd0);

        case (state_q)
            S_IDLE: begin
                if (ALE) begin
                    addr_d  = BusIn;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ALE) begin
                    err_d = 1'b1;
                end
                if (!nME && (!RnW || !nOE)) begin
                    mem_we_d   = !RnW;
                    if (!RnW) begin
                        wdata_d = BusIn;
                    end
                    mem_req_d  = 1'b1;
                    nwait_d    = 1'b0;
                    wait_cnt_d = WAIT_INIT;
                    to_cnt_d   = '0;
                    ack_seen_d = 1'b0;
                    state_d    = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (ALE) begin
                    err_d = 1'b1;
                end
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
                to_cnt_d = to_cnt_q + 8'd1;
                if (ack_ok) begin
                    ack_seen_d = 1'b1;
                    mem_req_d  = 1'b0;
                    if (!mem_we_q) begin
                        bus_out_d = MemRData;
                    end
                end
                // An ack in the last allowed cycle wins over the timeout.
                if (done_now) begin
                    state_d  = S_DONE;
                    nwait_d  = 1'b1;
                    mem_we_d = 1'b0;
                end else if (!ack_seen_q && !ack_ok && (to_cnt_q == TO_LAST)) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    nwait_d   = 1'b1;
                    state_d   = S_DONE;
                    if (!mem_we_q) begin
                        bus_out_d = 16'hFFFF;
                    end
                end
            end
            S_DONE: begin
                if (ALE) begin
                    addr_d  = BusIn;
                    state_d = S_ADDR;
                end else if (nME) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BusOut   = bus_out_q;
    assign nWait    = nwait_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Testbench for ext_mem_bridge: vector table, hand-written corner sequences
// and randomized accesses compared against a timing-rule reference model.
module tb_ext_mem_bridge;

    localparam int WS    = 1;
    localparam int TO    = 8;
    localparam int LIMIT = 40;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] BusIn;
    logic        ALE;
    logic        nME;
    logic        nOE;
    logic        RnW;
    logic [15:0] BusOut;
    logic        nWait;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemReq;
    logic        MemWe;
    logic [15:0] MemRData;
    logic        MemAck;
    logic        Err;

    ext_mem_bridge #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .BusIn    (BusIn),
        .ALE      (ALE),
        .nME      (nME),
        .nOE      (nOE),
        .RnW      (RnW),
        .BusOut   (BusOut),
        .nWait    (nWait),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemRData (MemRData),
        .MemAck   (MemAck),
        .Err      (Err)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic        nme;
        logic        noe;
        logic        rnw;
        logic [15:0] wdata;
        int          k;
        logic [15:0] rdata;
        int          exp_req;
        int          exp_wait;
        logic [15:0] exp_bus;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    // reference model state
    logic [15:0] m_bus;
    logic [15:0] m_wdata;
    logic        m_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic release_bus();
        nME = 1'b1;
        ALE = 1'b0;
        step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        step();
    endtask

    // Drives one bus access starting in the current slot and returns once the
    // DUT is back to nWait=1/MemReq=0. Ack is given in ACCESS slot k (second,
    // redundant ack in slot k2); ale_slot injects a stray ALE during ACCESS.
    task automatic run_access(input logic [15:0] addr, input logic nme, input logic noe,
                              input logic rnw, input logic [15:0] wdata, input int k,
                              input logic [15:0] rdata, input int k2, input logic [15:0] rdata2,
                              input bit ack_in_addr, input int ale_slot,
                              output int req_cyc, output int wait_cyc, output bit stable_ok);
        bit hung;
        req_cyc   = 0;
        wait_cyc  = 0;
        stable_ok = 1'b1;
        hung      = 1'b0;
        ALE    = 1'b1;
        BusIn  = addr;
        nME    = nme;
        nOE    = noe;
        RnW    = rnw;
        MemAck = 1'b0;
        step();
        ALE      = 1'b0;
        BusIn    = wdata;
        MemAck   = ack_in_addr;
        MemRData = 16'hDEAD;
        step();
        for (int c = 0; c <= LIMIT; c++) begin
            if (c == LIMIT) begin
                hung = 1'b1;
                break;
            end
            if (nWait && !MemReq) break;
            if (MemReq) req_cyc++;
            if (!nWait) wait_cyc++;
            if (MemAddr !== addr || MemWe !== !rnw || (!rnw && MemWData !== wdata))
                stable_ok = 1'b0;
            ALE      = (c == ale_slot);
            BusIn    = (c == ale_slot) ? 16'h9999 : wdata;
            MemAck   = (c == k) || (c == k2);
            MemRData = (c == k) ? rdata : rdata2;
            step();
        end
        MemAck = 1'b0;
        ALE    = 1'b0;
        check("no_hang", 32'(hung), 32'd0);
    endtask

    task automatic verify(input string tag, input logic [15:0] addr, input bit completed,
                          input int req, input int wt, input bit stable,
                          input int e_req, input int e_wait, input logic [15:0] e_bus,
                          input logic [15:0] e_wdata, input logic e_err);
        check({tag, "_req"},    32'(req), 32'(e_req));
        check({tag, "_wait"},   32'(wt), 32'(e_wait));
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_addr"},   32'(MemAddr), 32'(addr));
        check({tag, "_bus"},    32'(BusOut), 32'(e_bus));
        check({tag, "_wdata"},  32'(MemWData), 32'(e_wdata));
        check({tag, "_err"},    32'(Err), 32'(e_err));
        if (completed) check({tag, "_we"}, 32'(MemWe), 32'd0);
    endtask

    // Expected outcome from the timing rules: ack at ACCESS offset k completes
    // after max(k, WS)+1 stalled cycles; no ack by offset TO-1 times out.
    task automatic model_access(input logic nme, input logic noe, input logic rnw,
                                input logic [15:0] wdata, input int k, input logic [15:0] rdata,
                                output int e_req, output int e_wait, output bit completed);
        bit access;
        access    = !nme && (!rnw || !noe);
        e_req     = 0;
        e_wait    = 0;
        completed = 1'b0;
        if (access) begin
            if (!rnw) m_wdata = wdata;
            if (k >= 0 && k <= TO - 1) begin
                e_req     = k + 1;
                e_wait    = ((k > WS) ? k : WS) + 1;
                completed = 1'b1;
                if (rnw) m_bus = rdata;
            end else begin
                e_req  = TO;
                e_wait = TO;
                m_err  = 1'b1;
                if (rnw) m_bus = 16'hFFFF;
            end
        end
    endtask

    initial begin
        int          req, wt, e_req, e_wait, k, k2;
        bit          st, completed, ackaddr;
        logic [15:0] last_w, addr, wdata, rdata, rdata2;
        logic        nme, noe, rnw;

        //            addr      nme   noe   rnw   wdata     k   rdata     req wait bus       err
        tbl[0] = '{16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000,  0, 16'hBEEF, 1, 2, 16'hBEEF, 1'b0};
        tbl[1] = '{16'h00F0, 1'b0, 1'b1, 1'b0, 16'h5A5A,  4, 16'h0000, 5, 5, 16'hBEEF, 1'b0};
        tbl[2] = '{16'h7777, 1'b1, 1'b1, 1'b1, 16'h0000, -1, 16'h0000, 0, 0, 16'hBEEF, 1'b0};
        tbl[3] = '{16'h3333, 1'b0, 1'b1, 1'b1, 16'h0000, -1, 16'h0000, 0, 0, 16'hBEEF, 1'b0};
        tbl[4] = '{16'h2222, 1'b0, 1'b0, 1'b1, 16'h0000,  2, 16'h1111, 3, 3, 16'h1111, 1'b0};
        tbl[5] = '{16'h4000, 1'b0, 1'b0, 1'b1, 16'h0000, -1, 16'h0000, 8, 8, 16'hFFFF, 1'b1};
        tbl[6] = '{16'h00F2, 1'b0, 1'b1, 1'b0, 16'h0F0F,  1, 16'h0000, 2, 2, 16'hFFFF, 1'b1};
        tbl[7] = '{16'h0055, 1'b0, 1'b0, 1'b1, 16'h0000,  0, 16'hCAFE, 1, 2, 16'hCAFE, 1'b1};

        Reset    = 1'b1;
        BusIn    = 16'h0;
        ALE      = 1'b0;
        nME      = 1'b1;
        nOE      = 1'b1;
        RnW      = 1'b1;
        MemRData = 16'h0;
        MemAck   = 1'b0;
        #3;
        check("rst_nwait",  32'(nWait), 32'd1);
        check("rst_req",    32'(MemReq), 32'd0);
        check("rst_we",     32'(MemWe), 32'd0);
        check("rst_addr",   32'(MemAddr), 32'd0);
        check("rst_wdata",  32'(MemWData), 32'd0);
        check("rst_bus",    32'(BusOut), 32'd0);
        check("rst_err",    32'(Err), 32'd0);
        Reset = 1'b0;
        step();

        last_w = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            run_access(tbl[i].addr, tbl[i].nme, tbl[i].noe, tbl[i].rnw, tbl[i].wdata,
                       tbl[i].k, tbl[i].rdata, -1, 16'h0, 1'b0, -1, req, wt, st);
            if (!tbl[i].nme && !tbl[i].rnw) last_w = tbl[i].wdata;
            completed = !tbl[i].nme && (!tbl[i].rnw || !tbl[i].noe) &&
                        tbl[i].k >= 0 && tbl[i].k < TO;
            verify($sformatf("vec%0d", i), tbl[i].addr, completed, req, wt, st,
                   tbl[i].exp_req, tbl[i].exp_wait, tbl[i].exp_bus, last_w, tbl[i].exp_err);
            release_bus();
        end

        // reset in the middle of an access
        ALE   = 1'b1;
        BusIn = 16'h0BAD;
        nME   = 1'b0;
        nOE   = 1'b0;
        RnW   = 1'b1;
        step();
        ALE = 1'b0;
        step();
        step();
        check("midrst_pre_req",  32'(MemReq), 32'd1);
        check("midrst_pre_wait", 32'(nWait), 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_req",  32'(MemReq), 32'd0);
        check("midrst_wait", 32'(nWait), 32'd1);
        check("midrst_addr", 32'(MemAddr), 32'd0);
        check("midrst_err",  32'(Err), 32'd0);
        check("midrst_bus",  32'(BusOut), 32'd0);
        #2;
        Reset = 1'b0;
        nME   = 1'b1;
        step();
        run_access(16'h1357, 1'b0, 1'b0, 1'b1, 16'h0, 1, 16'h2468, -1, 16'h0, 1'b0, -1, req, wt, st);
        verify("postrst", 16'h1357, 1'b1, req, wt, st, 2, 2, 16'h2468, 16'h0000, 1'b0);
        release_bus();

        // stray ALE during ACCESS: flagged, access completes unchanged
        run_access(16'h0ABC, 1'b0, 1'b0, 1'b1, 16'h0, 2, 16'h7E57, -1, 16'h0, 1'b0, 0, req, wt, st);
        verify("protoerr", 16'h0ABC, 1'b1, req, wt, st, 3, 3, 16'h7E57, 16'h0000, 1'b1);
        release_bus();

        // back-to-back reads, second ALE in the DONE cycle of the first
        do_reset();
        run_access(16'h0001, 1'b0, 1'b0, 1'b1, 16'h0, 0, 16'hAAAA, -1, 16'h0, 1'b0, -1, req, wt, st);
        verify("b2b_a", 16'h0001, 1'b1, req, wt, st, 1, 2, 16'hAAAA, 16'h0000, 1'b0);
        run_access(16'h0002, 1'b0, 1'b0, 1'b1, 16'h0, 0, 16'h5555, -1, 16'h0, 1'b0, -1, req, wt, st);
        verify("b2b_b", 16'h0002, 1'b1, req, wt, st, 1, 2, 16'h5555, 16'h0000, 1'b0);
        release_bus();

        // randomized accesses against the reference model
        m_bus   = 16'h5555;
        m_wdata = 16'h0000;
        m_err   = 1'b0;
        for (int n = 0; n < 80; n++) begin
            addr    = 16'($urandom);
            wdata   = 16'($urandom);
            rdata   = 16'($urandom);
            rdata2  = 16'($urandom);
            rnw     = 1'($urandom_range(0, 1));
            nme     = ($urandom_range(0, 7) == 0);
            noe     = ($urandom_range(0, 5) == 0);
            k       = int'($urandom_range(0, 10));
            if (k == 10) k = -1;
            k2      = ($urandom_range(0, 1) == 1 && k >= 0) ? k + 1 + int'($urandom_range(0, 1)) : -1;
            ackaddr = ($urandom_range(0, 3) == 0);
            model_access(nme, noe, rnw, wdata, k, rdata, e_req, e_wait, completed);
            run_access(addr, nme, noe, rnw, wdata, k, rdata, k2, rdata2, ackaddr, -1, req, wt, st);
            verify($sformatf("rnd%0d", n), addr, completed, req, wt, st,
                   e_req, e_wait, m_bus, m_wdata, m_err);
            if ($urandom_range(0, 2) != 0) release_bus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
